io_bus_ctrl: RTL and testbench

//  Multi-cycle I/O port sequencer for the non-Mano IOR/IOW instructions.
//  The control unit raises a request in EX0; this block stalls the CU, runs a
//  4-phase strobe/ack handshake with an external peripheral, and returns read

---
 rtl/io_bus_ctrl.sv | 156 +++++++++++++++
 tb/tb_io_bus_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_ctrl.sv
// I/O port sequencer for IOR/IOW: stalls the CU and runs a 4-phase strobe/ack handshake.
// Latency: minimum 4 cycles from the accept edge to cu_done; a timeout bounds each wait at TIMEOUT cycles.
// Backpressure: cu_busy stalls the CU; cu_req is sampled only in IDLE, so one transaction runs per IDLE visit.
module io_bus_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cu_req,
    input  logic              cu_we,
    input  logic [ADDR_W-1:0] cu_addr,
    input  logic [DATA_W-1:0] cu_wdata,
    output logic              cu_busy,
    output logic              cu_done,
    output logic [DATA_W-1:0] cu_rdata,
    output logic              cu_err,
    output logic [ADDR_W-1:0] io_addr,
    output logic [DATA_W-1:0] io_wdata,
    output logic              io_rd,
    output logic              io_wr,
    input  logic              io_ack,
    input  logic [DATA_W-1:0] io_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        RELEASE,
        DONE
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              we_q, we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic [DATA_W-1:0] rdata_nxt;
    logic              err_nxt;
    logic              rd_nxt, wr_nxt, busy_nxt, done_nxt;

    // cnt holds the number of cycles already spent in the current wait state,
    // so cnt_plus is the count including the cycle now ending.
    logic [CNT_W:0]    cnt_plus;
    logic [CNT_W-1:0]  cnt_sat;
    logic              limit_hit;

    // Saturating increment and timeout detection for the wait counter
    always_comb begin
        cnt_plus  = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
        limit_hit = (cnt_plus >= (CNT_W + 1)'(TIMEOUT));
        cnt_sat   = (cnt == CNT_W'(TIMEOUT)) ? cnt : cnt + CNT_W'(1);
    end

    // Next-state and next-output logic; outputs are decoded from the next state
    // so that every output is driven straight from a flop.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        we_nxt    = we_q;
        addr_nxt  = io_addr;
        wdata_nxt = io_wdata;
        rdata_nxt = cu_rdata;
        err_nxt   = cu_err;

        case (state)
            IDLE: begin
                if (cu_req) begin
                    we_nxt    = cu_we;
                    addr_nxt  = cu_addr;
                    wdata_nxt = cu_wdata;
                    err_nxt   = 1'b0;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                cnt_nxt   = '0;
                state_nxt = STROBE;
            end
            STROBE: begin
                // An ack in the final allowed cycle still counts as a success.
                if (io_ack) begin
                    if (!we_q) begin
                        rdata_nxt = io_rdata;
                    end
                    cnt_nxt   = '0;
                    state_nxt = RELEASE;
                end else if (limit_hit) begin
                    err_nxt = 1'b1;
                    if (!we_q) begin
                        rdata_nxt = '1;
                    end
                    cnt_nxt   = '0;
                    state_nxt = RELEASE;
                end else begin
                    cnt_nxt = cnt_sat;
                end
            end
            RELEASE: begin
                if (!io_ack) begin
                    state_nxt = DONE;
                end else if (limit_hit) begin
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt_sat;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        rd_nxt   = (state_nxt == STROBE) && !we_nxt;
        wr_nxt   = (state_nxt == STROBE) && we_nxt;
        busy_nxt = (state_nxt == SETUP) || (state_nxt == STROBE) || (state_nxt == RELEASE);
        done_nxt = (state_nxt == DONE);
    end

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            we_q     <= 1'b0;
            io_addr  <= '0;
            io_wdata <= '0;
            io_rd    <= 1'b0;
            io_wr    <= 1'b0;
            cu_busy  <= 1'b0;
            cu_done  <= 1'b0;
            cu_rdata <= '0;
            cu_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            we_q     <= we_nxt;
            io_addr  <= addr_nxt;
            io_wdata <= wdata_nxt;
            io_rd    <= rd_nxt;
            io_wr    <= wr_nxt;
            cu_busy  <= busy_nxt;
            cu_done  <= done_nxt;
            cu_rdata <= rdata_nxt;
            cu_err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Bench for io_bus_ctrl: table of transactions run against a reactive peripheral,
// plus hand sequences for mid-transaction reset and back-to-back requests.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_io_bus_ctrl;

    localparam int NEVER = 1000;

    logic        clk;
    logic        rst;
    logic        cu_req;
    logic        cu_we;
    logic [15:0] cu_addr;
    logic [15:0] cu_wdata;
    logic        cu_busy;
    logic        cu_done;
    logic [15:0] cu_rdata;
    logic        cu_err;
    logic [15:0] io_addr;
    logic [15:0] io_wdata;
    logic        io_rd;
    logic        io_wr;
    logic        io_ack;
    logic [15:0] io_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    io_bus_ctrl #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(15)) dut (
        .clk      (clk),
        .rst      (rst),
        .cu_req   (cu_req),
        .cu_we    (cu_we),
        .cu_addr  (cu_addr),
        .cu_wdata (cu_wdata),
        .cu_busy  (cu_busy),
        .cu_done  (cu_done),
        .cu_rdata (cu_rdata),
        .cu_err   (cu_err),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .io_rd    (io_rd),
        .io_wr    (io_wr),
        .io_ack   (io_ack),
        .io_rdata (io_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] prd;       // data the peripheral returns
        int          ack_delay; // strobe cycles before ack rises
        int          hold;      // RELEASE cycles ack stays high
        int          exp_rd;
        int          exp_wr;
        int          exp_rel;
        int          exp_lat;   // cycles from accept edge to cu_done
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   rd_c, wr_c, rel_c, strb_c, lat, both;
        logic seen, stable, done_seen;
        logic [15:0] rd_v;
        logic er_v;
        rd_c = 0; wr_c = 0; rel_c = 0; strb_c = 0; lat = -1; both = 0;
        seen = 1'b0; stable = 1'b1; done_seen = 1'b0;
        rd_v = 16'h0; er_v = 1'b0;
        @(negedge clk);
        cu_req   = 1'b1;
        cu_we    = v.we;
        cu_addr  = v.addr;
        cu_wdata = v.wdata;
        io_ack   = 1'b0;
        io_rdata = 16'hDEAD;
        for (int c = 1; c <= 100 && !done_seen; c++) begin
            @(negedge clk);
            if (c == 1) begin
                // Scramble the CU inputs: the block must have captured them.
                cu_req   = 1'b0;
                cu_addr  = ~v.addr;
                cu_wdata = ~v.wdata;
            end
            if (io_rd && io_wr) both++;
            if (io_rd) rd_c++;
            if (io_wr) wr_c++;
            if (io_rd || io_wr) begin
                strb_c++;
                seen = 1'b1;
                if (io_addr !== v.addr || io_wdata !== v.wdata) stable = 1'b0;
                if (strb_c > v.ack_delay) begin
                    io_ack   = 1'b1;
                    io_rdata = v.prd;
                end
            end else if (cu_busy && seen) begin
                rel_c++;
                if (rel_c > v.hold) io_ack = 1'b0;
            end
            if (cu_done) begin
                done_seen = 1'b1;
                lat  = c;
                rd_v = cu_rdata;
                er_v = cu_err;
            end
        end
        io_ack = 1'b0;
        chk({tag, " latency"}, lat, v.exp_lat);
        chk({tag, " rd_cycles"}, rd_c, v.exp_rd);
        chk({tag, " wr_cycles"}, wr_c, v.exp_wr);
        chk({tag, " release_cycles"}, rel_c, v.exp_rel);
        chk({tag, " rd_wr_overlap"}, both, 0);
        chk({tag, " addr_data_stable"}, stable, 1'b1);
        chk({tag, " rdata"}, rd_v, v.exp_rdata);
        chk({tag, " err"}, er_v, v.exp_err);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, {cu_done, cu_busy}, 2'b00);
        chk({tag, " rdata_held"}, cu_rdata, v.exp_rdata);
        chk({tag, " addr_held"}, io_addr, v.addr);
    endtask

    // Reset asserted in the second STROBE cycle of a read.
    task automatic reset_mid_txn();
        int strb, dn, busy_c;
        strb = 0; dn = 0; busy_c = 0;
        @(negedge clk);
        cu_req = 1'b1; cu_we = 1'b0; cu_addr = 16'h0021; cu_wdata = 16'h0;
        io_ack = 1'b0;
        for (int c = 1; c <= 20 && strb < 2; c++) begin
            @(negedge clk);
            cu_req = 1'b0;
            if (io_rd) strb++;
        end
        chk("rst_reached_strobe2", strb, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_io_rd", io_rd, 1'b0);
        chk("rst_busy", cu_busy, 1'b0);
        chk("rst_done", cu_done, 1'b0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (cu_done) dn++;
            if (cu_busy) busy_c++;
        end
        chk("rst_no_done_after", dn, 0);
        chk("rst_stays_idle", busy_c, 0);
    endtask

    // cu_req held high: the second accept may only follow DONE -> IDLE.
    task automatic req_held();
        int done_n, first, second, both, busy5;
        done_n = 0; first = 0; second = 0; both = 0; busy5 = -1;
        @(negedge clk);
        cu_req = 1'b1; cu_we = 1'b0; cu_addr = 16'h0077; cu_wdata = 16'h0;
        io_ack = 1'b0; io_rdata = 16'h1111;
        for (int c = 1; c <= 40 && done_n < 2; c++) begin
            @(negedge clk);
            if (io_rd && io_wr) both++;
            io_ack = io_rd || io_wr;
            if (cu_done) begin
                done_n++;
                if (done_n == 1) first = c;
                else second = c;
            end
            if (c == 5) busy5 = int'(cu_busy);
        end
        cu_req = 1'b0;
        io_ack = 1'b0;
        chk("held_done_count", done_n, 2);
        chk("held_first_done", first, 4);
        chk("held_second_done", second, 9);
        chk("held_idle_gap", busy5, 0);
        chk("held_overlap", both, 0);
        chk("held_rdata", cu_rdata, 16'h1111);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vec_t post;
        //           we    addr      wdata     prd       dly    hold   rd  wr  rel lat rdata     err
        vecs[0] = '{1'b0, 16'h0012, 16'h0000, 16'hBEEF, 0,     0,     1,  0,  1,  4, 16'hBEEF, 1'b0};
        vecs[1] = '{1'b1, 16'h0003, 16'h5A5A, 16'h9999, 3,     0,     0,  4,  1,  7, 16'hBEEF, 1'b0};
        vecs[2] = '{1'b0, 16'h0040, 16'h0000, 16'h1234, NEVER, 0,     15, 0,  1, 18, 16'hFFFF, 1'b1};
        vecs[3] = '{1'b1, 16'h0007, 16'hA5A5, 16'h4321, 0,     NEVER, 0,  1, 15, 18, 16'hFFFF, 1'b1};
        vecs[4] = '{1'b0, 16'h00FF, 16'h0000, 16'h0F0F, 14,    0,     15, 0,  1, 18, 16'h0F0F, 1'b0};
        vecs[5] = '{1'b0, 16'h0100, 16'h0000, 16'h7777, 0,     14,    1,  0, 15, 18, 16'h7777, 1'b0};
        post    = '{1'b0, 16'h0055, 16'h0000, 16'hCAFE, 0,     0,     1,  0,  1,  4, 16'hCAFE, 1'b0};

        rst = 1'b1; cu_req = 1'b0; cu_we = 1'b0; cu_addr = '0; cu_wdata = '0;
        io_ack = 1'b0; io_rdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", cu_busy, 1'b0);
        chk("reset_done", cu_done, 1'b0);
        chk("reset_io_rd", io_rd, 1'b0);
        chk("reset_io_wr", io_wr, 1'b0);
        chk("reset_err", cu_err, 1'b0);
        chk("reset_rdata", cu_rdata, 16'h0);
        chk("reset_io_addr", io_addr, 16'h0);
        chk("reset_io_wdata", io_wdata, 16'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_req", cu_busy, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        reset_mid_txn();
        run_vec(post, "post_reset");
        req_held();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
